deserializer: RTL and testbench

Receive-side counterpart of the lab1 serializer. Collects an MSB-first bit stream qualified by a valid strobe and rebuilds parallel words with a length code in the serializer's own `data_mod` encoding. A frame ends either on the DATA_W-th bit or on the first idle cycle. The block sits directly on the serializer's `ser_data_o` / `ser_data_val_o` pair, so the two can be looped back in lab benches.

---
 rtl/deserializer.sv | 130 +++++++++++++
 tb/tb_deserializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
//
// Rebuilds parallel words from an MSB-first serial stream qualified by a valid
// strobe. This is the receive side of the lab serializer. A frame closes on
// its DATA_W-th bit, or on the first idle cycle after at least one bit.
//
// Frame endings:
//   - A full frame is reported with length code 0.
//   - A short frame of 3 or more bits is reported with length code = bit count.
//   - A runt frame of 1 or 2 bits is dropped and flagged on err_o.
//
// Ports:
//   clk_i             in   1       clock, rising edge
//   srst_i            in   1       synchronous reset, active-high
//   data_i            in   1       serial data bit
//   data_val_i        in   1       data_i valid this cycle
//   deser_data_o      out  DATA_W  rebuilt word, left-aligned (first bit = MSB)
//   deser_data_mod_o  out  MOD_W   valid bit count, DATA_W encoded as 0
//   deser_data_val_o  out  1       one-cycle strobe for data/mod
//   err_o             out  1       one-cycle pulse: runt frame dropped
//   rx_busy_o         out  1       a frame is partially collected
// -----------------------------------------------------------------------------
module deserializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
    output logic              err_o,
    output logic              rx_busy_o
);

    // Index of the last bit of a full frame, and the shortest frame worth reporting.
    localparam logic [MOD_W-1:0] CNT_LAST     = MOD_W'(DATA_W - 1);
    localparam logic [MOD_W-1:0] CNT_MIN_EMIT = MOD_W'(3);

    logic [DATA_W-1:0] sr_q,   sr_d;
    logic [MOD_W-1:0]  cnt_q,  cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MOD_W-1:0]  mod_q,  mod_d;
    logic              val_q,  val_d;
    logic              err_q,  err_d;
    logic              busy_q, busy_d;

    // Shift register with the incoming bit already placed at its position.
    logic [DATA_W-1:0] word_s;
    logic [MOD_W-1:0]  bit_pos_s;

    // State and output registers; reset wins over any data on the same edge.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sr_q   <= {DATA_W{1'b0}};
            cnt_q  <= {MOD_W{1'b0}};
            data_q <= {DATA_W{1'b0}};
            mod_q  <= {MOD_W{1'b0}};
            val_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            mod_q  <= mod_d;
            val_q  <= val_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    // Next-state logic: accept a bit, close a full frame, or close/drop on idle.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        mod_d  = mod_q;
        val_d  = 1'b0;
        err_d  = 1'b0;

        // Bit k of the frame lands at DATA_W-1-k, so the first bit ends up in the MSB.
        bit_pos_s         = CNT_LAST - cnt_q;
        word_s            = sr_q;
        word_s[bit_pos_s] = data_i;

        if (data_val_i) begin
            if (cnt_q == CNT_LAST) begin
                // The last bit goes straight to the output, which lets the
                // next cycle begin a new frame with no gap.
                data_d = word_s;
                mod_d  = {MOD_W{1'b0}};
                val_d  = 1'b1;
                sr_d   = {DATA_W{1'b0}};
                cnt_d  = {MOD_W{1'b0}};
            end else begin
                sr_d  = word_s;
                cnt_d = cnt_q + MOD_W'(1);
            end
        end else if (cnt_q >= CNT_MIN_EMIT) begin
            // Short frame: the LSBs that were never written are already 0 in sr_q.
            data_d = sr_q;
            mod_d  = cnt_q;
            val_d  = 1'b1;
            sr_d   = {DATA_W{1'b0}};
            cnt_d  = {MOD_W{1'b0}};
        end else if (cnt_q != {MOD_W{1'b0}}) begin
            // A 1- or 2-bit frame cannot be a serializer word, so flag it and drop it.
            err_d = 1'b1;
            sr_d  = {DATA_W{1'b0}};
            cnt_d = {MOD_W{1'b0}};
        end else begin
            // Idle with no frame in progress: hold.
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end

        busy_d = (cnt_d != {MOD_W{1'b0}});
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;
    assign err_o            = err_q;
    assign rx_busy_o        = busy_q;

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b0;
    logic          data_i = 1'b0;
    logic          data_val_i = 1'b0;
    logic [DW-1:0] deser_data_o;
    logic [MW-1:0] deser_data_mod_o;
    logic          deser_data_val_o;
    logic          err_o;
    logic          rx_busy_o;

    deserializer #(.DATA_W(DW), .MOD_W(MW)) dut (
        .clk_i            (clk_i),
        .srst_i           (srst_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .err_o            (err_o),
        .rx_busy_o        (rx_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model state: the bits of the frame collected so far, plus the expected outputs.
    bit            mbits[$];
    logic [DW-1:0] exp_data = '0;
    int            exp_mod  = 0;
    bit            exp_val  = 1'b0;
    bit            exp_err  = 1'b0;
    bit            exp_busy = 1'b0;

    // Record of the strobes and errors the model predicted.
    logic [DW-1:0] log_data[$];
    int            log_mod[$];
    int            log_cyc[$];
    int            err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Close the current frame of n bits: the word is the sum of the bit weights.
    task automatic model_emit(input int n);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++)
            if (mbits[i]) w = w + (16'h8000 >> i);
        exp_data = w;
        exp_mod  = n % DW;
        exp_val  = 1'b1;
        log_data.push_back(w);
        log_mod.push_back(n % DW);
        log_cyc.push_back(cyc);
        mbits.delete();
    endtask

    // Apply one cycle of inputs, advance the model, and compare every output.
    task automatic step(input bit rst, input bit v, input bit d);
        srst_i     = rst;
        data_val_i = v;
        data_i     = d;
        @(posedge clk_i);
        #1;
        cyc++;
        exp_val = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            mbits.delete();
            exp_data = '0;
            exp_mod  = 0;
        end else if (v) begin
            mbits.push_back(d);
            if (mbits.size() == DW) model_emit(DW);
        end else if (mbits.size() >= 3) begin
            model_emit(mbits.size());
        end else if (mbits.size() > 0) begin
            exp_err = 1'b1;
            err_cnt++;
            mbits.delete();
        end
        exp_busy = (mbits.size() != 0);
        chk("val",  deser_data_val_o, exp_val);
        chk("err",  err_o,            exp_err);
        chk("busy", rx_busy_o,        exp_busy);
        chk("data", deser_data_o,     exp_data);
        chk("mod",  deser_data_mod_o, exp_mod);
    endtask

    task automatic send(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, w[DW-1-i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_mod.delete();
        log_cyc.delete();
        err_cnt = 0;
    endtask

    initial begin
        int            c0;
        int            gap;
        int            n;
        int            nlog;
        int            nerr;
        logic [DW-1:0] w;
        logic [DW-1:0] mask;

        // Reset state.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("reset_data", deser_data_o, 32'h0);
        chk("reset_busy", rx_busy_o, 32'h0);
        idle(2);

        // Full word: the strobe appears on the edge that samples the 16th bit.
        clear_logs();
        send(16'hA5C3, 16);
        c0 = cyc;
        idle(2);
        chk("full_count", log_data.size(), 32'd1);
        if (log_data.size() == 1) begin
            chk("full_data", log_data[0], 32'hA5C3);
            chk("full_mod",  log_mod[0],  32'd0);
            chk("full_cyc",  log_cyc[0],  c0);
        end
        chk("full_err", err_cnt, 32'd0);

        // Partial word: bits 1,0,1,1,0 then idle.
        clear_logs();
        send(16'hB000, 5);
        idle(1);
        chk("part_count", log_data.size(), 32'd1);
        if (log_data.size() == 1) begin
            chk("part_data", log_data[0], 32'hB000);
            chk("part_mod",  log_mod[0],  32'd5);
        end
        chk("part_busy", rx_busy_o, 32'h0);
        idle(1);

        // Runt frame: 1,1 then idle, then a 3-bit frame 1,1,1.
        clear_logs();
        send(16'hC000, 2);
        idle(1);
        chk("runt_err",   err_cnt, 32'd1);
        chk("runt_nostb", log_data.size(), 32'd0);
        send(16'hE000, 3);
        idle(1);
        chk("three_count", log_data.size(), 32'd1);
        if (log_data.size() == 1) begin
            chk("three_data", log_data[0], 32'hE000);
            chk("three_mod",  log_mod[0],  32'd3);
        end

        // Back-to-back: two full words with no gap.
        clear_logs();
        send(16'h1234, 16);
        send(16'hFFFF, 16);
        idle(2);
        chk("b2b_count", log_data.size(), 32'd2);
        if (log_data.size() == 2) begin
            chk("b2b_data0", log_data[0], 32'h1234);
            chk("b2b_data1", log_data[1], 32'hFFFF);
            chk("b2b_mod1",  log_mod[1],  32'd0);
            chk("b2b_gap",   log_cyc[1] - log_cyc[0], 32'd16);
        end

        // Reset after 8 bits, with data present on the reset edge.
        clear_logs();
        send(16'hDEAD, 8);
        step(1'b1, 1'b1, 1'b1);
        send(16'hBEEF, 16);
        idle(1);
        chk("rst_count", log_data.size(), 32'd1);
        if (log_data.size() == 1) begin
            chk("rst_data", log_data[0], 32'hBEEF);
            chk("rst_mod",  log_mod[0],  32'd0);
        end
        chk("rst_err", err_cnt, 32'd0);

        // Loopback against a behavioural serializer: data_mod = t % 16, random gaps.
        clear_logs();
        for (int t = 0; t < 32; t++) begin
            w    = DW'($urandom);
            n    = (t % DW == 0) ? DW : (t % DW);
            nlog = log_data.size();
            nerr = err_cnt;
            gap  = (n == DW) ? $urandom_range(0, 3) : $urandom_range(1, 3);
            send(w, n);
            idle(gap);
            if (n <= 2) begin
                chk("lb_runt_nostb", log_data.size(), nlog);
                chk("lb_runt_err",   err_cnt, nerr + 1);
            end else begin
                mask = 16'hFFFF << (DW - n);
                chk("lb_count", log_data.size(), nlog + 1);
                if (log_data.size() == nlog + 1) begin
                    chk("lb_data", log_data[nlog], w & mask);
                    chk("lb_mod",  log_mod[nlog],  t % DW);
                end
            end
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
